// File: rtl/score_pkg.sv
// Shared constants and types for the score counter bank and its BCD converter.
package score_pkg;

    localparam int SCORE_BW     = 7;
    localparam int SCORE_MAX    = 99;
    localparam int SCORE_DIGITS = 2;
    localparam int BCD_W        = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/score_bin2bcd.sv
// Combinational double-dabble binary to BCD converter, least significant digit lowest.
module score_bin2bcd
    import score_pkg::*;
#(
    parameter int BW     = SCORE_BW,
    parameter int DIGITS = SCORE_DIGITS
) (
    input  logic [BW-1:0]           i_bin,
    output logic [DIGITS*BCD_W-1:0] o_bcd
);

    logic [DIGITS*BCD_W-1:0] w_bcd;
    bcd_digit_t              w_dig;

    always_comb begin
        w_bcd = '0;
        w_dig = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            // add-3 on any digit >= 5 before each shift keeps every digit decimal
            for (int d = 0; d < DIGITS; d++) begin
                w_dig = w_bcd[d*BCD_W +: BCD_W];
                if (w_dig > bcd_digit_t'(4)) begin
                    w_bcd[d*BCD_W +: BCD_W] = w_dig + bcd_digit_t'(3);
                end
            end
            w_bcd = {w_bcd[DIGITS*BCD_W-2:0], i_bin[i]};
        end
    end

    assign o_bcd = w_bcd;

endmodule

// File: rtl/score_counter_bank.sv
// N_CH independent up/down score counters with edge-detected requests and BCD outputs.
// Define SCORE_WRAP_EN to wrap at the limits instead of saturating (ovf is set either way).
module score_counter_bank
    import score_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int BW      = SCORE_BW,
    parameter int MAX_VAL = SCORE_MAX,
    parameter int DIGITS  = SCORE_DIGITS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_CH-1:0]               up_i,
    input  logic [N_CH-1:0]               down_i,
    input  logic [N_CH-1:0]               clr_i,
    output logic [N_CH*BW-1:0]            cnt_o,
    output logic [N_CH*BCD_W*DIGITS-1:0]  bcd_o,
    output logic [N_CH-1:0]               max_o,
    output logic [N_CH-1:0]               zero_o,
    output logic [N_CH-1:0]               ovf_o
);

    localparam logic [BW-1:0] MAX_C = BW'(MAX_VAL);

    for (genvar c = 0; c < N_CH; c++) begin : gen_ch
        logic          r_up_q;
        logic          r_down_q;
        logic [BW-1:0] r_cnt;
        logic          r_ovf;
        logic          w_up_evt;
        logic          w_down_evt;

        assign w_up_evt   = up_i[c]   & ~r_up_q;
        assign w_down_evt = down_i[c] & ~r_down_q;

        // edge registers track inputs even in reset/clear so held levels never step later
        always_ff @(posedge clk_i) begin
            r_up_q   <= up_i[c];
            r_down_q <= down_i[c];
            if (rst_i || clr_i[c]) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_up_evt && !w_down_evt) begin
                if (r_cnt < MAX_C) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_ovf <= 1'b1;
`ifdef SCORE_WRAP_EN
                    r_cnt <= '0;
`endif
                end
            end else if (w_down_evt && !w_up_evt) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_ovf <= 1'b1;
`ifdef SCORE_WRAP_EN
                    r_cnt <= MAX_C;
`endif
                end
            end
        end

        score_bin2bcd #(
            .BW     (BW),
            .DIGITS (DIGITS)
        ) u_bin2bcd (
            .i_bin (r_cnt),
            .o_bcd (bcd_o[c*BCD_W*DIGITS +: BCD_W*DIGITS])
        );

        assign cnt_o[c*BW +: BW] = r_cnt;
        assign max_o[c]          = (r_cnt == MAX_C);
        assign zero_o[c]         = (r_cnt == '0);
        assign ovf_o[c]          = r_ovf;
    end

endmodule

// File: tb/tb_score_counter_bank.sv
// Directed self-checking bench for score_counter_bank (both builds via SCORE_WRAP_EN).
module tb_score_counter_bank;

    localparam int N_CH = 2;
    localparam int BW   = 7;
    localparam int DG   = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [N_CH-1:0]       up_i;
    logic [N_CH-1:0]       down_i;
    logic [N_CH-1:0]       clr_i;
    logic [N_CH*BW-1:0]    cnt_o;
    logic [N_CH*4*DG-1:0]  bcd_o;
    logic [N_CH-1:0]       max_o;
    logic [N_CH-1:0]       zero_o;
    logic [N_CH-1:0]       ovf_o;

    int n_vec = 0;
    int n_err = 0;

    score_counter_bank #(.N_CH(N_CH), .BW(BW), .MAX_VAL(99), .DIGITS(DG)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .up_i   (up_i),
        .down_i (down_i),
        .clr_i  (clr_i),
        .cnt_o  (cnt_o),
        .bcd_o  (bcd_o),
        .max_o  (max_o),
        .zero_o (zero_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int c);
        return 32'(cnt_o[c*BW +: BW]);
    endfunction

    function automatic logic [31:0] bcd(input int c);
        return 32'(bcd_o[c*4*DG +: 4*DG]);
    endfunction

    task automatic pulse_up(input int c);
        up_i[c] = 1'b1;
        step();
        up_i[c] = 1'b0;
        step();
    endtask

    initial begin
        rst_i  = 1'b1;
        up_i   = 2'b01;
        down_i = '0;
        clr_i  = '0;
        step(); step(); step();
        check("rst_cnt",  32'(cnt_o),  32'h0);
        check("rst_bcd",  32'(bcd_o),  32'h0);
        check("rst_zero", 32'(zero_o), 32'h3);
        check("rst_max",  32'(max_o),  32'h0);
        check("rst_ovf",  32'(ovf_o),  32'h0);

        // up held through reset release must not step
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("held_rst_cnt0",  cnt(0), 32'd0);
        check("held_rst_zero0", 32'(zero_o[0]), 32'd1);
        up_i = '0;
        step();

        for (int k = 1; k <= 5; k++) begin
            up_i[0] = 1'b1;
            step();
            check("ch0_up_lat1", cnt(0), 32'(k));
            up_i[0] = 1'b0;
            step();
        end
        check("ch0_bcd5",  bcd(0), 32'h05);
        check("ch1_idle",  cnt(1), 32'd0);

        // a held level is a single step
        up_i[0] = 1'b1;
        step(); step(); step();
        check("ch0_held_one_step", cnt(0), 32'd6);
        up_i[0] = 1'b0;
        step();

        for (int k = 1; k <= 99; k++) pulse_up(1);
        check("ch1_at_99",   cnt(1), 32'd99);
        check("ch1_max",     32'(max_o[1]), 32'd1);
        check("ch1_bcd99",   bcd(1), 32'h99);
        check("ch1_no_ovf",  32'(ovf_o[1]), 32'd0);
        up_i[1] = 1'b1;
        step();
`ifdef SCORE_WRAP_EN
        check("ch1_wrap_cnt",  cnt(1), 32'd0);
        check("ch1_wrap_zero", 32'(zero_o[1]), 32'd1);
`else
        check("ch1_sat_cnt",   cnt(1), 32'd99);
        check("ch1_sat_max",   32'(max_o[1]), 32'd1);
`endif
        check("ch1_ovf",     32'(ovf_o[1]), 32'd1);
        check("ch0_indep",   cnt(0), 32'd6);
        check("ch0_no_ovf",  32'(ovf_o[0]), 32'd0);
        up_i[1] = 1'b0;
        step();

        clr_i = 2'b11;
        step();
        clr_i = '0;
        check("clr_cnt", 32'(cnt_o), 32'h0);
        check("clr_ovf", 32'(ovf_o), 32'h0);
        step();

        down_i[0] = 1'b1;
        step();
`ifdef SCORE_WRAP_EN
        check("ch0_dn_wrap_cnt", cnt(0), 32'd99);
        check("ch0_dn_wrap_bcd", bcd(0), 32'h99);
`else
        check("ch0_dn_sat_cnt",  cnt(0), 32'd0);
        check("ch0_dn_sat_zero", 32'(zero_o[0]), 32'd1);
`endif
        check("ch0_dn_ovf", 32'(ovf_o[0]), 32'd1);
        down_i[0] = 1'b0;
        step();
        clr_i[0] = 1'b1;
        step();
        clr_i[0] = 1'b0;
        check("ch0_clr_cnt", cnt(0), 32'd0);
        check("ch0_clr_ovf", 32'(ovf_o[0]), 32'd0);
        step();

        // an edge arriving during clear is consumed
        up_i[0]  = 1'b1;
        clr_i[0] = 1'b1;
        step();
        clr_i[0] = 1'b0;
        step();
        check("ch0_clr_eats_edge", cnt(0), 32'd0);
        up_i[0] = 1'b0;
        step();

        for (int k = 1; k <= 42; k++) pulse_up(0);
        check("ch0_at_42",  cnt(0), 32'd42);
        check("ch0_bcd42",  bcd(0), 32'h42);
        up_i[0]   = 1'b1;
        down_i[0] = 1'b1;
        step();
        check("ch0_both_hold", cnt(0), 32'd42);
        up_i[0]   = 1'b0;
        down_i[0] = 1'b0;
        step();
        up_i[0] = 1'b1;
        step();
        check("ch0_up_after_both", cnt(0), 32'd43);
        up_i[0] = 1'b0;
        step();
        down_i[0] = 1'b1;
        step();
        check("ch0_down_step", cnt(0), 32'd42);
        down_i[0] = 1'b0;
        step();

        for (int k = 1; k <= 37; k++) pulse_up(1);
        check("ch1_at_37", cnt(1), 32'd37);
        up_i[1] = 1'b1;
        rst_i   = 1'b1;
        step();
        check("ch1_rst_mid", cnt(1), 32'd0);
        check("ch0_rst_mid", cnt(0), 32'd0);
        rst_i = 1'b0;
        step(); step();
        check("ch1_no_step_after_rst", cnt(1), 32'd0);
        up_i[1] = 1'b0;
        step();
        pulse_up(1);
        check("ch1_step_after_release", cnt(1), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
